// File: rtl/case_1_mul_pkg.sv
// case_1_mul_pkg: shared limits, the stage record shape and the result
// narrowing helper used by the pipelined multiplier.

`define CASE_1_MUL_STAGE_REC_T(W) struct packed { logic vld; logic [(W)-1:0] data; }

package case_1_mul_pkg;

   // Deepest pipeline the multiplier supports.
   localparam int MAX_STAGE = 8;

   // Working width of the narrowing helper; full products must be narrower.
   localparam int MAX_W = 64;

   // Narrow a full product (already extended to MAX_W) to outW bits.
   // Returns {ovf, narrowed}; the narrowed value sits in the low outW bits.
   // With satEn set, an out-of-range product clamps to the nearest bound.
   function automatic logic [MAX_W:0] sat_narrow(
      input logic [MAX_W-1:0] full,
      input int               outW,
      input logic             isSigned,
      input logic             satEn
   );
      logic [MAX_W-1:0] mask;
      logic [MAX_W-1:0] hiVal;
      logic [MAX_W-1:0] loVal;
      logic [MAX_W-1:0] res;
      logic             ovf;
      mask = '0;
      for (int i = 0; i < MAX_W; i++) begin
         if (i < outW) begin
            mask[i] = 1'b1;
         end
      end
      if (isSigned) begin
         hiVal = mask >> 1;
         loVal = ~hiVal;
         ovf   = ($signed(full) > $signed(hiVal)) || ($signed(full) < $signed(loVal));
      end else begin
         hiVal = mask;
         loVal = '0;
         ovf   = (full > mask);
      end
      res = full;
      if (satEn && ovf) begin
         res = (isSigned && full[MAX_W-1]) ? loVal : hiVal;
      end
      return {ovf, res & mask};
   endfunction

endpackage

// File: rtl/case_1_mul_pipe_stage.sv
// case_1_mul_pipe_stage: one pipeline slot holding a valid bit and a data
// word; loads when enabled, holds otherwise, clears on synchronous reset.

module case_1_mul_pipe_stage
   import case_1_mul_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en_i,
   input  logic         vld_i,
   input  logic [W-1:0] data_i,
   output logic         vld_o,
   output logic [W-1:0] data_o
);

   typedef `CASE_1_MUL_STAGE_REC_T(W) stageRecT;

   stageRecT stage_q;
   stageRecT stage_d;

   // Next slot contents: take the upstream record when the pipe advances.
   always_comb begin
      stage_d = stage_q;
      if (en_i) begin
         stage_d.vld  = vld_i;
         stage_d.data = data_i;
      end
   end

   // Slot register; reset drops whatever was in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         stage_q <= '0;
      end else begin
         stage_q <= stage_d;
      end
   end

   assign vld_o  = stage_q.vld;
   assign data_o = stage_q.data;

endmodule

// File: rtl/case_1_mul_pipe_hs.sv
// case_1_mul_pipe_hs: NUM_STAGE-deep registered multiplier with valid/ready
// handshake on both sides. Operands are extended per their signedness, the
// full product is formed after the first stage and narrowed in the last.
// Define CASE_1_MUL_PIPE_SAT_EN to clamp overflowing results instead of
// wrapping them; ovf is reported either way.

module case_1_mul_pipe_hs
   import case_1_mul_pkg::*;
#(
   parameter int ID          = 1,
   parameter int NUM_STAGE   = 3,
   parameter int din0_WIDTH  = 8,
   parameter int din1_WIDTH  = 4,
   parameter int dout_WIDTH  = 8,
   parameter int din0_SIGNED = 1,
   parameter int din1_SIGNED = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_vld,
   output logic                  in_rdy,
   input  logic [din0_WIDTH-1:0] din0,
   input  logic [din1_WIDTH-1:0] din1,
   output logic                  out_vld,
   input  logic                  out_rdy,
   output logic [dout_WIDTH-1:0] dout,
   output logic                  ovf
);

   localparam int   P      = din0_WIDTH + din1_WIDTH;
   localparam int   DW     = dout_WIDTH;
   localparam int   NumStg = (NUM_STAGE < 1) ? 1 :
                             (NUM_STAGE > MAX_STAGE) ? MAX_STAGE : NUM_STAGE;
   localparam logic ASgn   = (din0_SIGNED != 0);
   localparam logic BSgn   = (din1_SIGNED != 0);
   localparam logic ResSgn = ASgn | BSgn;
   localparam int   unusedId = ID;

`ifdef CASE_1_MUL_PIPE_SAT_EN
   localparam logic SatEn = 1'b1;
`else
   localparam logic SatEn = 1'b0;
`endif

   logic           adv;
   logic [P-1:0]   aExt;
   logic [P-1:0]   bExt;
   logic           prodVld;
   logic [P-1:0]   fullProd;
   logic [MAX_W:0] narrowRes;
   logic [DW:0]    outNext;
   logic [DW:0]    outQ;
   logic           outVld;
   logic           unusedNarrowBits;

   // The whole pipe moves together; it only stops when a result is held.
   assign adv    = ~outVld | out_rdy;
   assign in_rdy = adv;

   // Unsigned operands zero-extend, so a mixed pair yields a signed product.
   assign aExt = {{(P-din0_WIDTH){din0[din0_WIDTH-1] & ASgn}}, din0};
   assign bExt = {{(P-din1_WIDTH){din1[din1_WIDTH-1] & BSgn}}, din1};

   generate
      if (NumStg == 1) begin : gSingle
         // Single register: extend, multiply and narrow all feed it directly.
         assign prodVld  = in_vld;
         assign fullProd = aExt * bExt;
      end else begin : gMulti
         logic         opVld;
         logic [2*P-1:0] opQ;
         logic [P-1:0] opA;
         logic [P-1:0] opB;
         logic         vldChain  [NumStg-1];
         logic [P-1:0] prodChain [NumStg-1];

         case_1_mul_pipe_stage #(.W(2*P)) uOperands (
            .clk    (clk),
            .reset  (reset),
            .en_i   (adv),
            .vld_i  (in_vld),
            .data_i ({aExt, bExt}),
            .vld_o  (opVld),
            .data_o (opQ)
         );

         // Low P bits of the modular product are exact for every signedness.
         assign {opA, opB}   = opQ;
         assign vldChain[0]  = opVld;
         assign prodChain[0] = opA * opB;

         for (genvar k = 1; k < NumStg - 1; k++) begin : gRetime
            case_1_mul_pipe_stage #(.W(P)) uRetime (
               .clk    (clk),
               .reset  (reset),
               .en_i   (adv),
               .vld_i  (vldChain[k-1]),
               .data_i (prodChain[k-1]),
               .vld_o  (vldChain[k]),
               .data_o (prodChain[k])
            );
         end

         assign prodVld  = vldChain[NumStg-2];
         assign fullProd = prodChain[NumStg-2];
      end
   endgenerate

   assign narrowRes = sat_narrow({{(MAX_W-P){fullProd[P-1] & ResSgn}}, fullProd},
                                 DW, ResSgn, SatEn);
   assign outNext          = {narrowRes[MAX_W], narrowRes[DW-1:0]};
   assign unusedNarrowBits = ^narrowRes[MAX_W-1:DW];

   case_1_mul_pipe_stage #(.W(DW+1)) uOutput (
      .clk    (clk),
      .reset  (reset),
      .en_i   (adv),
      .vld_i  (prodVld),
      .data_i (outNext),
      .vld_o  (outVld),
      .data_o (outQ)
   );

   assign out_vld = outVld;
   assign ovf     = outQ[DW];
   assign dout    = outQ[DW-1:0];

endmodule

// File: tb/tb_case_1_mul_pipe_hs.sv
// tb_case_1_mul_pipe_hs: directed checks of the pipelined multiplier against
// an arithmetic reference, for a default signed instance and a one-stage
// unsigned instance with a 12-bit result.

module tb_case_1_mul_pipe_hs;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   logic       inVldA, inRdyA, outVldA, outRdyA, ovfA;
   logic [7:0] din0A, doutA;
   logic [3:0] din1A;

   logic        inVldB, inRdyB, outVldB, outRdyB, ovfB;
   logic [7:0]  din0B;
   logic [3:0]  din1B;
   logic [11:0] doutB;

   case_1_mul_pipe_hs dutA (
      .clk(clk), .reset(reset), .in_vld(inVldA), .in_rdy(inRdyA),
      .din0(din0A), .din1(din1A), .out_vld(outVldA), .out_rdy(outRdyA),
      .dout(doutA), .ovf(ovfA)
   );

   case_1_mul_pipe_hs #(
      .ID(2), .NUM_STAGE(1), .din0_WIDTH(8), .din1_WIDTH(4), .dout_WIDTH(12),
      .din0_SIGNED(0), .din1_SIGNED(0)
   ) dutB (
      .clk(clk), .reset(reset), .in_vld(inVldB), .in_rdy(inRdyB),
      .din0(din0B), .din1(din1B), .out_vld(outVldB), .out_rdy(outRdyB),
      .dout(doutB), .ovf(ovfB)
   );

   // Compare one value and keep the tallies.
   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
      end
   endtask

   // Reference: exact product, range test, then wrap or clamp to w bits.
   function automatic logic [32:0] refMul(input longint a, input longint b,
                                          input int w, input logic sgn);
      longint full, hi, lo, res;
      logic   ov;
      full = a * b;
      if (sgn) begin
         hi = (64'sd1 <<< (w - 1)) - 1;
         lo = -(64'sd1 <<< (w - 1));
      end else begin
         hi = (64'sd1 <<< w) - 1;
         lo = 0;
      end
      ov  = (full > hi) || (full < lo);
      res = full;
`ifdef CASE_1_MUL_PIPE_SAT_EN
      if (ov) res = (full < 0) ? lo : hi;
`endif
      res = res & ((64'sd1 <<< w) - 1);
      return {ov, res[31:0]};
   endfunction

   // Scoreboard for instance A.
   logic [32:0] expA [$];
   int          accA [$];
   int          cycA = 0;
   int          popA = 0;
   logic        holdA = 1'b0, heldOvfA, rdyExpA, latOkA;
   logic [7:0]  heldDoutA;

   // Every cycle, just before the edge: handshake rule, hold rule, results.
   always @(negedge clk) begin
      #4;
      cycA++;
      if (reset) begin
         expA.delete();
         accA.delete();
         holdA = 1'b0;
      end else begin
         rdyExpA = ~outVldA | outRdyA;
         checkOutput("A in_rdy", inRdyA, rdyExpA);
         if (holdA) begin
            checkOutput("A hold vld", outVldA, 1);
            checkOutput("A hold dout", doutA, heldDoutA);
            checkOutput("A hold ovf", ovfA, heldOvfA);
         end
         if (outVldA) begin
            if (expA.size() == 0) begin
               checkOutput("A unexpected result", outVldA, 0);
            end else begin
               checkOutput("A dout", doutA, expA[0][7:0]);
               checkOutput("A ovf", ovfA, expA[0][32]);
               latOkA = (cycA - accA[0]) >= 3;
               checkOutput("A latency", latOkA, 1);
               if (outRdyA) begin
                  void'(expA.pop_front());
                  void'(accA.pop_front());
                  popA++;
               end
            end
         end
         if (inVldA && inRdyA) begin
            expA.push_back(refMul(longint'($signed(din0A)), longint'($signed(din1A)), 8, 1'b1));
            accA.push_back(cycA);
         end
         holdA     = outVldA & ~outRdyA;
         heldDoutA = doutA;
         heldOvfA  = ovfA;
      end
   end

   // Scoreboard for instance B.
   logic [32:0] expB [$];
   logic        rdyExpB;

   // Same per-cycle comparison for the one-stage unsigned instance.
   always @(negedge clk) begin
      #4;
      if (reset) begin
         expB.delete();
      end else begin
         rdyExpB = ~outVldB | outRdyB;
         checkOutput("B in_rdy", inRdyB, rdyExpB);
         if (outVldB) begin
            if (expB.size() == 0) begin
               checkOutput("B unexpected result", outVldB, 0);
            end else begin
               checkOutput("B dout", doutB, expB[0][11:0]);
               checkOutput("B ovf", ovfB, expB[0][32]);
               if (outRdyB) void'(expB.pop_front());
            end
         end
         if (inVldB && inRdyB) begin
            expB.push_back(refMul(longint'(din0B), longint'(din1B), 12, 1'b0));
         end
      end
   end

   // Offer one pair to instance A and wait (bounded) until it is taken.
   task automatic applyStimulus(input logic [7:0] a, input logic [3:0] b);
      logic acc;
      int   waited;
      acc    = 1'b0;
      waited = 0;
      din0A  = a;
      din1A  = b;
      inVldA = 1'b1;
      while (!acc && waited < 40) begin
         #4;
         acc = inRdyA;
         @(negedge clk);
         waited++;
      end
      if (!acc) checkOutput("A accept timeout", 0, 1);
      inVldA = 1'b0;
   endtask

   // Wait (bounded) for instance A to deliver everything outstanding.
   task automatic drainA();
      int waited;
      waited = 0;
      while ((expA.size() != 0 || outVldA) && waited < 60) begin
         @(negedge clk);
         #4;
         waited++;
      end
      checkOutput("A drain", expA.size(), 0);
      @(negedge clk);
   endtask

   logic [7:0]  tblA0 [10] = '{8'd7, 8'h80, 8'd127, 8'hFF, 8'd100, 8'hCE, 8'd0, 8'd16, 8'h80, 8'd85};
   logic [3:0]  tblA1 [10] = '{4'hD, 4'h8, 4'h7, 4'hF, 4'h3, 4'h8, 4'h5, 4'h8, 4'h7, 4'h2};
   logic [7:0]  tblB0 [4]  = '{8'd255, 8'd200, 8'd1, 8'd0};
   logic [3:0]  tblB1 [4]  = '{4'd15, 4'd3, 4'd1, 4'd9};
   logic [11:0] tblBx [4]  = '{12'hEF1, 12'h258, 12'h001, 12'h000};
   logic [32:0] satExp1024, satExp889;
   int          popBase;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   // Directed sequence: reset, single products, stalled stream, reset in flight, instance B.
   initial begin
      reset  = 1'b1;
      inVldA = 1'b0; outRdyA = 1'b1; din0A = '0; din1A = '0;
      inVldB = 1'b0; outRdyB = 1'b1; din0B = '0; din1B = '0;
`ifdef CASE_1_MUL_PIPE_SAT_EN
      satExp1024 = {1'b1, 32'h7F};
      satExp889  = {1'b1, 32'h7F};
`else
      satExp1024 = {1'b1, 32'h00};
      satExp889  = {1'b1, 32'h79};
`endif
      checkOutput("model 7*-3", refMul(7, -3, 8, 1'b1), {1'b0, 32'hEB});
      checkOutput("model -128*-8", refMul(-128, -8, 8, 1'b1), satExp1024);
      checkOutput("model 127*7", refMul(127, 7, 8, 1'b1), satExp889);
      checkOutput("model 255*15 u12", refMul(255, 15, 12, 1'b0), {1'b0, 32'hEF1});

      repeat (2) @(negedge clk);
      reset = 1'b0;
      #4;
      checkOutput("reset A out_vld", outVldA, 0);
      checkOutput("reset A dout", doutA, 0);
      checkOutput("reset A ovf", ovfA, 0);
      checkOutput("reset A in_rdy", inRdyA, 1);
      checkOutput("reset B out_vld", outVldB, 0);
      checkOutput("reset B dout", doutB, 0);
      @(negedge clk);

      applyStimulus(8'd7, 4'hD);
      #4;
      checkOutput("lat +1 out_vld", outVldA, 0);
      @(negedge clk); #4;
      checkOutput("lat +2 out_vld", outVldA, 0);
      @(negedge clk); #4;
      checkOutput("lat +3 out_vld", outVldA, 1);
      checkOutput("7*-3 dout", doutA, 8'hEB);
      checkOutput("7*-3 ovf", ovfA, 0);
      @(negedge clk);

      applyStimulus(8'h80, 4'h8);
      #4;
      @(negedge clk); #4;
      @(negedge clk); #4;
      checkOutput("-128*-8 out_vld", outVldA, 1);
      checkOutput("-128*-8 dout", doutA, satExp1024[7:0]);
      checkOutput("-128*-8 ovf", ovfA, 1);
      @(negedge clk);
      drainA();

      popBase = popA;
      fork
         begin
            for (int i = 0; i < 10; i++) applyStimulus(tblA0[i], tblA1[i]);
         end
         begin
            outRdyA = 1'b1;
            repeat (5) @(negedge clk);
            outRdyA = 1'b0;
            #4;
            checkOutput("stall in_rdy", inRdyA, 0);
            checkOutput("stall out_vld", outVldA, 1);
            repeat (4) @(negedge clk);
            outRdyA = 1'b1;
         end
      join
      drainA();
      checkOutput("stream result count", popA - popBase, 10);

      applyStimulus(8'd5, 4'd3);
      applyStimulus(8'd9, 4'd2);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      #4;
      checkOutput("mid-reset out_vld", outVldA, 0);
      checkOutput("mid-reset dout", doutA, 0);
      repeat (5) @(negedge clk);
      #4;
      checkOutput("post-reset out_vld", outVldA, 0);
      @(negedge clk);

      for (int i = 0; i < 4; i++) begin
         din0B  = tblB0[i];
         din1B  = tblB1[i];
         inVldB = 1'b1;
         #4;
         checkOutput("B accept", inRdyB, 1);
         if (i > 0) begin
            checkOutput("B stream vld", outVldB, 1);
            checkOutput("B stream dout", doutB, tblBx[i-1]);
         end
         @(negedge clk);
      end
      inVldB = 1'b0;
      #4;
      checkOutput("B last vld", outVldB, 1);
      checkOutput("B last dout", doutB, tblBx[3]);
      @(negedge clk); #4;
      checkOutput("B idle vld", outVldB, 0);
      checkOutput("B queue empty", expB.size(), 0);
      checkOutput("A queue empty", expA.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
